// File: rtl/neighbor_match_node.sv
// neighbor_match_node
// Time-multiplexed comparison node for the grid fabric. A request captures
// a self value and N neighbour values, then one neighbour is compared per
// clock against the self value using the captured relation. The per-neighbour
// matches are reduced with the captured combine rule, and the final match
// vector, match count and result bit are published together with a
// one-cycle done pulse. Published results stay stable until the next
// evaluation completes.

module neighbor_match_node #(
   parameter int W  = 2,
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [W-1:0]    self_val,
   input  logic [N*W-1:0]  nbr_vals,
   input  logic [1:0]      mode,
   input  logic [1:0]      combine,
   input  logic [CW-1:0]   thresh,
   output logic            busy,
   output logic            done,
   output logic            result,
   output logic [CW-1:0]   match_count,
   output logic [N-1:0]    match_vec
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] MODE_EQ = 2'b00;
   localparam logic [1:0] MODE_GT = 2'b01;
   localparam logic [1:0] MODE_LT = 2'b10;

   localparam logic [1:0] COMB_ANY    = 2'b00;
   localparam logic [1:0] COMB_ALL    = 2'b01;
   localparam logic [1:0] COMB_THRESH = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t          state_q,   state_d;
   logic [IW-1:0]   idx_q,     idx_d;
   logic [W-1:0]    self_q,    self_d;
   logic [N*W-1:0]  nbr_q,     nbr_d;
   logic [1:0]      mode_q,    mode_d;
   logic [1:0]      combine_q, combine_d;
   logic [CW-1:0]   thresh_q,  thresh_d;
   logic [N-1:0]    accVec_q,  accVec_d;
   logic [CW-1:0]   accCnt_q,  accCnt_d;
   logic            result_q,  result_d;
   logic [CW-1:0]   count_q,   count_d;
   logic [N-1:0]    vec_q,     vec_d;

   logic [W-1:0]    curNbr;
   logic            hit;
   logic            lastIdx;
   logic            reduced;

   // Select the neighbour under test and evaluate the captured relation on it
   always_comb begin
      curNbr  = nbr_q[idx_q*W +: W];
      lastIdx = (idx_q == IW'(N - 1));
      hit     = 1'b0;
      case (mode_q)
         MODE_EQ: hit = (self_q == curNbr);
         MODE_GT: hit = (self_q >  curNbr);
         MODE_LT: hit = (self_q <  curNbr);
         default: hit = (self_q != curNbr);
      endcase
   end

   // Next-state logic: accept requests, step through neighbours, publish results
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      self_d    = self_q;
      nbr_d     = nbr_q;
      mode_d    = mode_q;
      combine_d = combine_q;
      thresh_d  = thresh_q;
      accVec_d  = accVec_q;
      accCnt_d  = accCnt_q;
      result_d  = result_q;
      count_d   = count_q;
      vec_d     = vec_q;
      reduced   = 1'b0;

      if ((state_q == IDLE || state_q == DONE) && start) begin
         self_d    = self_val;
         nbr_d     = nbr_vals;
         mode_d    = mode;
         combine_d = combine;
         thresh_d  = thresh;
         accVec_d  = '0;
         accCnt_d  = '0;
         idx_d     = '0;
         state_d   = SCAN;
      end else if (state_q == SCAN) begin
         accVec_d = accVec_q | (N'(hit) << idx_q);
         accCnt_d = accCnt_q + CW'(hit);
         case (combine_q)
            COMB_ANY:    reduced = (accCnt_d != '0);
            COMB_ALL:    reduced = (accCnt_d == CW'(N));
            COMB_THRESH: reduced = (accCnt_d >= thresh_q);
            default:     reduced = (accCnt_d == '0);
         endcase
         if (lastIdx) begin
            vec_d    = accVec_d;
            count_d  = accCnt_d;
            result_d = reduced;
            state_d  = DONE;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end else begin
         state_d = IDLE;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         self_q    <= '0;
         nbr_q     <= '0;
         mode_q    <= '0;
         combine_q <= '0;
         thresh_q  <= '0;
         accVec_q  <= '0;
         accCnt_q  <= '0;
         result_q  <= 1'b0;
         count_q   <= '0;
         vec_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         self_q    <= self_d;
         nbr_q     <= nbr_d;
         mode_q    <= mode_d;
         combine_q <= combine_d;
         thresh_q  <= thresh_d;
         accVec_q  <= accVec_d;
         accCnt_q  <= accCnt_d;
         result_q  <= result_d;
         count_q   <= count_d;
         vec_q     <= vec_d;
      end
   end

   assign busy        = (state_q == SCAN);
   assign done        = (state_q == DONE);
   assign result      = result_q;
   assign match_count = count_q;
   assign match_vec   = vec_q;

endmodule

// File: tb/tb_neighbor_match_node.sv
// Testbench for neighbor_match_node (W=2, N=4). Expected results come from
// a behavioural model, are queued when a request is issued and are checked
// when done pulses.

module tb_neighbor_match_node;

   localparam int W  = 2;
   localparam int N  = 4;
   localparam int CW = 3;

   typedef struct packed {
      logic [N-1:0]  vec;
      logic [CW-1:0] cnt;
      logic          res;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            start;
   logic [W-1:0]    selfVal;
   logic [N*W-1:0]  nbrVals;
   logic [1:0]      mode;
   logic [1:0]      combine;
   logic [CW-1:0]   thresh;
   logic            busy;
   logic            done;
   logic            result;
   logic [CW-1:0]   matchCount;
   logic [N-1:0]    matchVec;

   int   vectorCount = 0;
   int   missCount   = 0;
   exp_t expQ[$];
   exp_t lastExp = '0;

   neighbor_match_node #(.W(W), .N(N), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .self_val    (selfVal),
      .nbr_vals    (nbrVals),
      .mode        (mode),
      .combine     (combine),
      .thresh      (thresh),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .match_count (matchCount),
      .match_vec   (matchVec)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectorCount++;
      if (obs !== expv) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [N*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
      logic [N*W-1:0] v;
      v = {W'(a3), W'(a2), W'(a1), W'(a0)};
      return v;
   endfunction

   // Reference model of one evaluation
   function automatic exp_t model(input logic [W-1:0] s, input logic [N*W-1:0] nv,
                                  input logic [1:0] md, input logic [1:0] cb, input logic [CW-1:0] th);
      exp_t e;
      int   cnt;
      logic m;
      logic [W-1:0] nb;
      e   = '0;
      cnt = 0;
      for (int i = 0; i < N; i++) begin
         nb = nv[i*W +: W];
         case (md)
            2'b00:   m = (s == nb);
            2'b01:   m = (s > nb);
            2'b10:   m = (s < nb);
            default: m = (s != nb);
         endcase
         e.vec[i] = m;
         if (m) cnt++;
      end
      e.cnt = CW'(cnt);
      case (cb)
         2'b00:   e.res = (cnt != 0);
         2'b01:   e.res = (cnt == N);
         2'b10:   e.res = (cnt >= int'(th));
         default: e.res = (cnt == 0);
      endcase
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a request for one edge and queue the model's expectation
   task automatic applyStimulus(input int s, input logic [N*W-1:0] nv,
                                input logic [1:0] md, input logic [1:0] cb, input int th);
      selfVal = W'(s);
      nbrVals = nv;
      mode    = md;
      combine = cb;
      thresh  = CW'(th);
      expQ.push_back(model(W'(s), nv, md, cb, CW'(th)));
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Wait for done, counting busy cycles; returns at the negedge of the done cycle
   task automatic waitDone(input string tag, input bit checkBusy);
      int  busyCnt;
      bit  seen;
      busyCnt = 0;
      seen    = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) busyCnt++;
      end
      checkOutput({tag, "_doneSeen"}, 32'(seen), 1);
      if (checkBusy) checkOutput({tag, "_busyCycles"}, busyCnt, N);
   endtask

   // Scoreboard: pop on done, also check exclusivity and output hold during scan
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (busy && done) checkOutput("busyDoneOverlap", 1, 0);
         if (done) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedDone", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("matchVec", 32'(matchVec), 32'(e.vec));
               checkOutput("matchCount", 32'(matchCount), 32'(e.cnt));
               checkOutput("result", 32'(result), 32'(e.res));
               lastExp = e;
            end
         end else if (busy) begin
            if ({matchVec, matchCount, result} !== lastExp) begin
               checkOutput("holdDuringScan", 32'({matchVec, matchCount, result}), 32'(lastExp));
            end
         end
      end
   end

   // Directed sequence
   initial begin
      int gap;
      bit seen;
      rst     = 1'b0;
      start   = 1'b1;
      selfVal = '0;
      nbrVals = '0;
      mode    = '0;
      combine = '0;
      thresh  = '0;

      // Reset held with start asserted
      tick();
      checkOutput("rstDone1", 32'(done), 0);
      tick();
      @(negedge clk);
      checkOutput("rstBusy", 32'(busy), 0);
      checkOutput("rstDone", 32'(done), 0);
      checkOutput("rstResult", 32'(result), 0);
      checkOutput("rstCount", 32'(matchCount), 0);
      checkOutput("rstVec", 32'(matchVec), 0);
      start = 1'b0;
      rst   = 1'b1;
      tick();
      tick();

      // EQ / ANY
      applyStimulus(2, pack4(1, 2, 3, 0), 2'b00, 2'b00, 0);
      waitDone("eqAny", 1'b1);
      tick();

      // GT / ALL, both outcomes
      applyStimulus(3, pack4(0, 1, 2, 2), 2'b01, 2'b01, 0);
      waitDone("gtAll3", 1'b1);
      tick();
      applyStimulus(2, pack4(0, 1, 2, 2), 2'b01, 2'b01, 0);
      waitDone("gtAll2", 1'b1);
      tick();

      // LT / THRESH at 3, 4 and 0
      applyStimulus(0, pack4(1, 0, 3, 2), 2'b10, 2'b10, 3);
      waitDone("ltTh3", 1'b1);
      tick();
      applyStimulus(0, pack4(1, 0, 3, 2), 2'b10, 2'b10, 4);
      waitDone("ltTh4", 1'b1);
      tick();
      applyStimulus(0, pack4(1, 0, 3, 2), 2'b10, 2'b10, 0);
      waitDone("ltTh0", 1'b1);
      tick();

      // NE / THRESH with threshold above N
      applyStimulus(1, pack4(0, 2, 3, 1), 2'b11, 2'b10, 5);
      waitDone("neTh5", 1'b1);
      tick();

      // Start pulsed during SCAN with different inputs is ignored
      applyStimulus(2, pack4(1, 2, 3, 0), 2'b00, 2'b00, 0);
      selfVal = 2'd0;
      nbrVals = pack4(0, 0, 0, 0);
      mode    = 2'b11;
      combine = 2'b11;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      waitDone("scanStart", 1'b0);

      // Back-to-back: start in the DONE cycle
      tick();
      applyStimulus(3, pack4(3, 3, 0, 3), 2'b00, 2'b01, 0);
      waitDone("b2bFirst", 1'b1);
      selfVal = 2'd0;
      nbrVals = pack4(3, 1, 0, 2);
      mode    = 2'b01;
      combine = 2'b10;
      thresh  = 3'd2;
      expQ.push_back(model(2'd0, pack4(3, 1, 0, 2), 2'b01, 2'b10, 3'd2));
      start   = 1'b1;
      tick();
      start   = 1'b0;
      selfVal = 2'd3;
      nbrVals = pack4(0, 0, 0, 0);
      mode    = 2'b00;
      combine = 2'b00;
      thresh  = 3'd0;
      gap  = 1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else gap++;
      end
      checkOutput("b2bGap", gap, N + 1);
      tick();

      // Abort at idx==2
      applyStimulus(1, pack4(1, 1, 1, 1), 2'b00, 2'b01, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      void'(expQ.pop_back());
      lastExp = '0;
      @(negedge clk);
      checkOutput("abortBusy", 32'(busy), 0);
      checkOutput("abortDone", 32'(done), 0);
      checkOutput("abortResult", 32'(result), 0);
      checkOutput("abortCount", 32'(matchCount), 0);
      checkOutput("abortVec", 32'(matchVec), 0);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checkOutput("abortNoDone", 32'(seen), 0);
      tick();

      // EQ / NONE after abort
      applyStimulus(3, pack4(0, 1, 2, 0), 2'b00, 2'b11, 0);
      waitDone("eqNone", 1'b1);
      tick();
      tick();

      checkOutput("queueEmpty", expQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/neighbor_match_node.md
# neighbor_match_node

Parametrised, time-multiplexed comparison node for the grid fabric. On `start` it captures a self value and N neighbour values. It then compares one neighbour per clock against the self value using a selectable relation, and reduces the per-neighbour matches with a selectable combine rule. It reports a match vector, a match count and a single result bit with a one-cycle `done` pulse.

## Interface
- `W`, default 2: bit width of the self value and of each neighbour value.
- `N`, default 4: neighbour count, N ≥ 1.
- `CW`, default $clog2(N+1): width of the count and threshold fields.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a new evaluation.
- `self_val`  in  W  self value.
- `nbr_vals`  in  N*W  neighbour values; neighbour i is `nbr_vals[i*W +: W]`.
- `mode`  in  2  compare relation: 00 self==nbr, 01 self>nbr, 10 self<nbr, 11 self!=nbr. Comparisons are unsigned.
- `combine`  in  2  reduction rule: 00 ANY, 01 ALL, 10 THRESH, 11 NONE.
- `thresh`  in  CW  minimum match count for THRESH.
- `busy`  out  1  high while scanning.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  1  reduced result.
- `match_count`  out  CW  number of matching neighbours.
- `match_vec`  out  N  bit i set when neighbour i matched.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `start`=1 at an edge is accepted. At that edge the block captures `self_val`, `nbr_vals`, `mode`, `combine` and `thresh` into internal registers. It clears the internal accumulators, sets idx=0 and moves to SCAN.
- SCAN: each edge compares captured neighbour idx against the captured self value. A match sets accumulator bit idx and increments the accumulator count. When idx==N-1, the state moves to DONE; otherwise idx increments.
- On the edge that leaves SCAN, the outputs update:
  - `match_vec` and `match_count` take the final accumulator values.
  - `result` is ANY: count≠0; ALL: count==N; THRESH: count≥thresh; NONE: count==0.
- THRESH with thresh=0 gives result 1. THRESH with thresh>N gives result 0.
- DONE lasts exactly one cycle, then returns to IDLE.
  - `start`=1 sampled at the edge leaving DONE is accepted exactly as from IDLE, which allows back-to-back operation.
- `start` is ignored in SCAN.
- Input changes after the accept edge have no effect on the current evaluation.
- `result`, `match_count` and `match_vec` hold their values until the edge that leaves the next SCAN. They do not change during SCAN.
- Count arithmetic is unsigned, CW bits wide, and cannot overflow because N ≤ 2^CW-1.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, idx=0, all accumulators 0. Outputs `busy`, `done`, `result`, `match_count` and `match_vec` are all 0.
- Reset has priority over `start` and over every state.
- Reset during SCAN or DONE aborts the evaluation. No `done` pulse is produced and the outputs are zeroed.
- Let E0 be the accept edge:
  - `busy` is high for the N cycles after E0.
  - Neighbour i is evaluated at edge E(i+1).
  - Outputs update at EN.
  - `done`=1 and `busy`=0 in the cycle after EN.
- Latency from the accept edge to the edge where `done` is sampled high is N+1 edges. For N=4, the cycle after E4 has `done` high.
- Minimum start-to-start period is N+1 cycles.
- `busy` and `done` are never high together.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `start`=1 → all outputs 0, `busy`=0, and no `done` appears.
- EQ/ANY with W=2, N=4: self=2, nbrs {1,2,3,0} (neighbour 0 first), start → exactly 4 busy cycles, then `done` pulse with `match_vec`=0010, `match_count`=1, `result`=1.
- GT/ALL: self=3, nbrs {0,1,2,2} → `match_vec`=1111, count 4, result 1. Repeat with self=2 → `match_vec`=0011, count 2, result 0.
- LT/THRESH: self=0, nbrs {1,0,3,2}, thresh=3 → `match_vec`=1101, count 3, result 1. Repeat with thresh=4 → result 0. Repeat with thresh=0 → result 1.
- Handshake:
  - Pulse `start` during SCAN with different inputs → ignored; first-run values are reported.
  - Assert `start` in the DONE cycle → accepted; the second `done` arrives 5 cycles after the first; inputs changed after the accept edge do not alter the result.
- Abort: drive `rst`=0 for one cycle while idx=2 → no `done`, outputs 0, state IDLE. A following EQ/NONE run with self=3, nbrs {0,1,2,0} → count 0, result 1.
